// File: rtl/key_pkg.sv
// Shared constants, per-key FSM state and per-key event payload for the key debouncer.
package key_pkg;

    localparam int unsigned KEY_TICK_20MS_12M = 240000;
    localparam int unsigned KEY_LONG_1S       = 50;
    localparam int unsigned KEY_REPEAT_200MS  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } key_state_e;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic lng;
        logic rpt;
    } key_evt_t;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: tick-sampled debounce, press/hold/long/repeat FSM, registered events.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = KEY_LONG_1S,
    parameter int unsigned REPEAT_TICKS = KEY_REPEAT_200MS
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     tick_i,
    input  logic     key_i,
    output key_evt_t evt_o
);

    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
    localparam int unsigned RPT_W  = (REPEAT_TICKS == 0) ? 1 : $clog2(REPEAT_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
    localparam logic [RPT_W-1:0]  RPT_MAX  = RPT_W'(REPEAT_TICKS);

    key_state_e        state_q, state_d;
    logic              sample_q, sample_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    key_evt_t          evt_q, evt_d;
    logic              level_q, level_d;
    logic              rise_c, fall_c;

    assign level_q = evt_q.level;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sample_q  <= 1'b0;
            hold_q    <= '0;
            rpt_cnt_q <= '0;
            evt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            hold_q    <= hold_d;
            rpt_cnt_q <= rpt_cnt_d;
            evt_q     <= evt_d;
        end
    end

    // Level flips only when the current and previous tick samples both disagree with it.
    always_comb begin
        sample_d = sample_q;
        level_d  = level_q;
        if (tick_i) begin
            sample_d = key_i;
            if ((key_i != level_q) && (sample_q != level_q)) begin
                level_d = ~level_q;
            end
        end
    end

    assign rise_c = level_d & ~level_q;
    assign fall_c = ~level_d & level_q;

    // A falling level wins over any long/repeat threshold on the same tick.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rpt_cnt_d = rpt_cnt_q;
        evt_d     = '0;
        evt_d.level = level_d;
        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d     = HELD;
                    hold_d      = '0;
                    evt_d.press = 1'b1;
                end
            end
            HELD: begin
                if (fall_c) begin
                    state_d   = IDLE;
                    evt_d.rel = 1'b1;
                end else if (tick_i && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (hold_d == HOLD_MAX) begin
                        state_d   = LONG;
                        rpt_cnt_d = '0;
                        evt_d.lng = 1'b1;
                    end
                end
            end
            LONG: begin
                if (fall_c) begin
                    state_d   = IDLE;
                    evt_d.rel = 1'b1;
                end else if (tick_i && (REPEAT_TICKS != 0)) begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    if (rpt_cnt_d == RPT_MAX) begin
                        rpt_cnt_d = '0;
                        evt_d.rpt = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/key_debounce_array.sv
// Multi-key debouncer: shared sampling tick, polarity + 2-flop sync, per-key channels, key code.
module key_debounce_array
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned TICK_PERIOD  = KEY_TICK_20MS_12M,
    parameter int unsigned LONG_TICKS   = KEY_LONG_1S,
    parameter int unsigned REPEAT_TICKS = KEY_REPEAT_200MS,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic [7:0]          key_code
);

    localparam int unsigned CNT_W = $clog2(TICK_PERIOD);

    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                tick_c;
    logic [NUM_KEYS-1:0] pol_c;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [7:0]          code_q, code_d;
    logic [7:0]          idx_c;
    logic [3:0]          hits_c;
    key_evt_t            evt [NUM_KEYS];

    assign tick_c     = (tick_cnt_q == CNT_W'(TICK_PERIOD - 1));
    assign tick_cnt_d = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
    assign pol_c      = ACTIVE_LOW ? ~key_in : key_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tick_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            code_q     <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= pol_c;
            sync2_q    <= sync1_q;
            code_q     <= code_d;
        end
    end

    // Single pressed key -> index+1, none -> 0, several -> keep last code.
    always_comb begin
        hits_c = '0;
        idx_c  = '0;
        code_d = code_q;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (key_level[i]) begin
                hits_c = hits_c + 4'd1;
                idx_c  = 8'(i + 1);
            end
        end
        if (hits_c == 4'd0) begin
            code_d = '0;
        end else if (hits_c == 4'd1) begin
            code_d = idx_c;
        end
    end

    assign key_code = code_q;

    for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_chan
        key_debounce_chan #(
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_chan (
            .clk_i  (clk_in),
            .rst_i  (rst_in),
            .tick_i (tick_c),
            .key_i  (sync2_q[g]),
            .evt_o  (evt[g])
        );
        assign key_level[g]   = evt[g].level;
        assign key_press[g]   = evt[g].press;
        assign key_release[g] = evt[g].rel;
        assign key_long[g]    = evt[g].lng;
        assign key_repeat[g]  = evt[g].rpt;
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array: TICK_PERIOD=4, LONG_TICKS=3, REPEAT_TICKS=2 (and 0).
module tb_key_debounce_array;

    logic       clk_in;
    logic       rst_in;
    logic [3:0] key_in;

    logic [3:0] lvl, prs, rel, lng, rep;
    logic [7:0] code;
    logic [3:0] nr_lvl, nr_prs, nr_rel, nr_lng, nr_rep;
    logic [7:0] nr_code;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int prs_n [4] = '{default: 0};
    int rel_n [4] = '{default: 0};
    int lng_n [4] = '{default: 0};
    int rep_n [4] = '{default: 0};
    int nr_lng_n = 0;
    int nr_rep_n = 0;

    key_debounce_array #(
        .NUM_KEYS(4), .TICK_PERIOD(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .key_in(key_in),
        .key_level(lvl), .key_press(prs), .key_release(rel),
        .key_long(lng), .key_repeat(rep), .key_code(code)
    );

    key_debounce_array #(
        .NUM_KEYS(4), .TICK_PERIOD(4), .LONG_TICKS(3), .REPEAT_TICKS(0), .ACTIVE_LOW(1'b1)
    ) dut_nr (
        .clk_in(clk_in), .rst_in(rst_in), .key_in(key_in),
        .key_level(nr_lvl), .key_press(nr_prs), .key_release(nr_rel),
        .key_long(nr_lng), .key_repeat(nr_rep), .key_code(nr_code)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clk_in) begin
        for (int k = 0; k < 4; k++) begin
            if (prs[k]) prs_n[k]++;
            if (rel[k]) rel_n[k]++;
            if (lng[k]) lng_n[k]++;
            if (rep[k]) rep_n[k]++;
            if (nr_lng[k]) nr_lng_n++;
            if (nr_rep[k]) nr_rep_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        rst_in = 1'b1;
        key_in = 4'hF;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_init_level", 32'(lvl), 32'h0);
        chk("rst_init_code", 32'(code), 32'h0);

        // Reset test: press key 0, then reset mid-count while it is held
        rst_in = 1'b0; key_in[0] = 1'b0; cyc = 0;
        step_to(7);  chk("a_pre_level", 32'(lvl), 32'h0);
        step_to(8);  chk("a_press", 32'(prs), 32'h1);
                     chk("a_level", 32'(lvl), 32'h1);
        step_to(9);  chk("a_code", 32'(code), 32'h1);
                     chk("a_press_one_clk", 32'(prs), 32'h0);
        step_to(10);
        rst_in = 1'b1;
        #1;
        chk("rst_level", 32'(lvl), 32'h0);
        chk("rst_press", 32'(prs), 32'h0);
        chk("rst_release", 32'(rel), 32'h0);
        chk("rst_long", 32'(lng), 32'h0);
        chk("rst_repeat", 32'(rep), 32'h0);
        chk("rst_code", 32'(code), 32'h0);
        step(); step();
        chk("rst_hold_rel", 32'(rel), 32'h0);
        rst_in = 1'b0; cyc = 0;
        step_to(7);  chk("r_pre_press", 32'(prs), 32'h0);
                     chk("r_pre_level", 32'(lvl), 32'h0);
        step_to(8);  chk("r_press", 32'(prs), 32'h1);
        step_to(9);  chk("r_code", 32'(code), 32'h1);
        key_in[0] = 1'b1;
        step_to(15); chk("r_level_held", 32'(lvl), 32'h1);
        step_to(16); chk("r_release", 32'(rel), 32'h1);
                     chk("r_level_off", 32'(lvl), 32'h0);
        step_to(17); chk("r_code_off", 32'(code), 32'h0);
        chk("r_rel_count", 32'(rel_n[0]), 32'd1);

        // Clean press/release of key 1
        step_to(20); key_in[1] = 1'b0;
        step_to(27); chk("b_pre_level", 32'(lvl), 32'h0);
        step_to(28); chk("b_press", 32'(prs), 32'h2);
                     chk("b_level", 32'(lvl), 32'h2);
                     chk("b_code_lag", 32'(code), 32'h0);
        step_to(29); chk("b_code", 32'(code), 32'h2);
        key_in[1] = 1'b1;
        step_to(36); chk("b_release", 32'(rel), 32'h2);
                     chk("b_level_off", 32'(lvl), 32'h0);
        step_to(37); chk("b_code_off", 32'(code), 32'h0);
        chk("b_press_count", 32'(prs_n[1]), 32'd1);
        chk("b_rel_count", 32'(rel_n[1]), 32'd1);

        // Glitch on key 2 spanning one tick
        step_to(40); key_in[2] = 1'b0;
        step_to(43); key_in[2] = 1'b1;
        step_to(45); chk("c_level_a", 32'(lvl), 32'h0);
        step_to(52); chk("c_level_b", 32'(lvl), 32'h0);
        chk("c_press_count", 32'(prs_n[2]), 32'd0);
        chk("c_rel_count", 32'(rel_n[2]), 32'd0);

        // Long press and auto-repeat on key 3
        key_in[3] = 1'b0;
        step_to(60); chk("d_press", 32'(prs), 32'h8);
        step_to(61); chk("d_code", 32'(code), 32'h4);
        step_to(71); chk("d_pre_long", 32'(lng), 32'h0);
        step_to(72); chk("d_long", 32'(lng), 32'h8);
                     chk("d_nr_long", 32'(nr_lng), 32'h8);
        step_to(73); chk("d_long_one_clk", 32'(lng), 32'h0);
        step_to(79); chk("d_pre_repeat", 32'(rep), 32'h0);
        step_to(80); chk("d_repeat1", 32'(rep), 32'h8);
                     chk("d_nr_repeat", 32'(nr_rep), 32'h0);
        step_to(100); key_in[3] = 1'b1;
        step_to(104); chk("d_repeat4", 32'(rep), 32'h8);
        step_to(108); chk("d_release", 32'(rel), 32'h8);
                      chk("d_level_off", 32'(lvl), 32'h0);
                      chk("d_nr_release", 32'(nr_rel), 32'h8);
        step_to(109); chk("d_code_off", 32'(code), 32'h0);
        chk("d_repeat_count", 32'(rep_n[3]), 32'd4);
        chk("d_long_count", 32'(lng_n[3]), 32'd1);
        chk("d_nr_repeat_count", 32'(nr_rep_n), 32'd0);
        chk("d_nr_long_count", 32'(nr_lng_n), 32'd1);

        // Overlapping keys 0 and 1
        step_to(112); key_in[0] = 1'b0;
        step_to(120); chk("e_press0", 32'(prs), 32'h1);
        step_to(121); chk("e_code1", 32'(code), 32'h1);
        key_in[1] = 1'b0;
        step_to(128); chk("e_press1", 32'(prs), 32'h2);
                      chk("e_level", 32'(lvl), 32'h3);
        step_to(129); chk("e_code_hold", 32'(code), 32'h1);
        key_in[0] = 1'b1;
        step_to(132); chk("e_long0", 32'(lng), 32'h1);
        step_to(136); chk("e_release0", 32'(rel), 32'h1);
                      chk("e_level1", 32'(lvl), 32'h2);
        step_to(137); chk("e_code2", 32'(code), 32'h2);
        key_in[1] = 1'b1;
        step_to(140); chk("e_long1", 32'(lng), 32'h2);
        step_to(144); chk("e_release1", 32'(rel), 32'h2);
        step_to(145); chk("e_code_off", 32'(code), 32'h0);

        // Simultaneous press of keys 0 and 2
        step_to(148); key_in = 4'b1010;
        step_to(156); chk("s_press", 32'(prs), 32'h5);
                      chk("s_level", 32'(lvl), 32'h5);
        step_to(157); chk("s_code_multi", 32'(code), 32'h0);
        key_in = 4'hF;
        step_to(164); chk("s_release", 32'(rel), 32'h5);

        // Release coinciding with the long threshold on key 3
        step_to(168); key_in[3] = 1'b0;
        step_to(176); chk("f_press", 32'(prs), 32'h8);
        step_to(180); key_in[3] = 1'b1;
        step_to(184); chk("f_level_held", 32'(lvl), 32'h8);
        step_to(188); chk("f_release", 32'(rel), 32'h8);
                      chk("f_no_long", 32'(lng), 32'h0);
                      chk("f_nr_no_long", 32'(nr_lng), 32'h0);
        step_to(192);
        chk("f_long_count", 32'(lng_n[3]), 32'd1);
        chk("t_press0_count", 32'(prs_n[0]), 32'd4);
        chk("t_rel0_count", 32'(rel_n[0]), 32'd3);
        chk("t_nr_repeat_count", 32'(nr_rep_n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
